imul_accum_unit: RTL and testbench



---
 rtl/imul_accum_pkg.sv | 13 +
 rtl/imul_accum_unit.sv | 78 +++++++
 tb/tb_imul_accum_unit.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/imul_accum_pkg.sv
// Shared types and constants for the product accumulator that sits behind the
// iterative integer multiplier.
package imul_accum_pkg;

    localparam int c_msg_nbits = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/imul_accum_unit.sv
// Sums a runtime-sized group of consecutive 32-bit products (mod 2^32) and
// emits one sum per group on a val/rdy stream.
module imul_accum_unit
    import imul_accum_pkg::*;
#(
    parameter int p_len_nbits = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [p_len_nbits-1:0] cfg_len,
    input  logic                   istream_val,
    output logic                   istream_rdy,
    input  logic [c_msg_nbits-1:0] istream_msg,
    output logic                   ostream_val,
    input  logic                   ostream_rdy,
    output logic [c_msg_nbits-1:0] ostream_msg,
    output logic [p_len_nbits-1:0] ostream_cnt,
    output logic                   busy
);

    state_t                 state, state_n;
    logic [c_msg_nbits-1:0] acc;
    logic [p_len_nbits-1:0] cnt, len_r;
    logic [p_len_nbits-1:0] eff_len, cnt_inc;
    logic                   in_xfer, out_xfer;

    // Every output is a function of state alone, so there is no
    // combinational path from either valid to either ready.
    assign istream_rdy = (state != DONE);
    assign ostream_val = (state == DONE);
    assign ostream_msg = (state == DONE) ? acc : '0;
    assign ostream_cnt = (state == DONE) ? cnt : '0;
    assign busy        = (state != IDLE);

    assign in_xfer  = istream_val && istream_rdy;
    assign out_xfer = ostream_val && ostream_rdy;
    assign eff_len  = (cfg_len == '0) ? p_len_nbits'(1) : cfg_len;
    // cnt stays below len_r while accumulating, so this cannot wrap.
    assign cnt_inc  = cnt + p_len_nbits'(1);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_xfer) state_n = (eff_len == p_len_nbits'(1)) ? DONE : ACCUM;
            ACCUM:   if (in_xfer && cnt_inc == len_r) state_n = DONE;
            DONE:    if (out_xfer) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            len_r <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (in_xfer) begin
                    len_r <= eff_len;   // length latched once; later cfg_len edits ignored
                    acc   <= istream_msg;
                    cnt   <= p_len_nbits'(1);
                end
                ACCUM: if (in_xfer) begin
                    acc <= acc + istream_msg;
                    cnt <= cnt_inc;
                end
                DONE: if (out_xfer) begin
                    acc <= '0;
                    cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imul_accum_unit.sv
// Self-checking bench for imul_accum_unit: directed scenarios plus randomized
// groups checked against a queue-based sum model.
module tb_imul_accum_unit;
    localparam int LW = 8;

    logic          clk = 0;
    logic          reset;
    logic [LW-1:0] cfg_len;
    logic          istream_val;
    logic          istream_rdy;
    logic [31:0]   istream_msg;
    logic          ostream_val;
    logic          ostream_rdy;
    logic [31:0]   ostream_msg;
    logic [LW-1:0] ostream_cnt;
    logic          busy;

    int total = 0;
    int bad   = 0;

    imul_accum_unit #(.p_len_nbits(LW)) dut (
        .clk(clk), .reset(reset), .cfg_len(cfg_len),
        .istream_val(istream_val), .istream_rdy(istream_rdy), .istream_msg(istream_msg),
        .ostream_val(ostream_val), .ostream_rdy(ostream_rdy), .ostream_msg(ostream_msg),
        .ostream_cnt(ostream_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic display_trace();
        $display("trace t=%0t st=%0d acc=%h cnt=%0d ival=%b irdy=%b oval=%b ordy=%b",
                 $time, dut.state, dut.acc, dut.cnt, istream_val, istream_rdy,
                 ostream_val, ostream_rdy);
    endtask

    // Present one product and let the next posedge take it; returns #1 after the edge.
    task automatic beat(input logic [31:0] m);
        istream_val = 1'b1;
        istream_msg = m;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cfg_len = '0; istream_val = 0; istream_msg = '0; ostream_rdy = 1'b1;
        #2;
        total++;
        if (istream_rdy !== 1'b1 || ostream_val !== 1'b0 || ostream_msg !== 32'd0 ||
            ostream_cnt !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got irdy=%b oval=%b msg=%h cnt=%0d busy=%b want 1 0 0 0 0",
                     istream_rdy, ostream_val, ostream_msg, ostream_cnt, busy);
        end
        @(posedge clk); #1; reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        cfg_len = 8'd3;
        beat(32'd6);
        beat(32'd20);
        istream_val = 1'b1; istream_msg = 32'd12;
        @(negedge clk);
        total++;
        if (ostream_val !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL basic_early_val got oval=%b busy=%b want 0 1", ostream_val, busy);
        end
        @(posedge clk); #1; istream_val = 0;
        @(negedge clk);
        total++;
        if (ostream_val !== 1'b1 || ostream_msg !== 32'd38 || ostream_cnt !== 8'd3 || istream_rdy !== 1'b0) begin
            bad++;
            $display("FAIL basic_sum got val=%b msg=%0d cnt=%0d irdy=%b want 1 38 3 0",
                     ostream_val, ostream_msg, ostream_cnt, istream_rdy);
        end
        display_trace();
        @(posedge clk); #1;
        total++;
        if (ostream_val !== 1'b0 || istream_rdy !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL basic_release got oval=%b irdy=%b busy=%b want 0 1 0", ostream_val, istream_rdy, busy);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] prods [4];
        logic [31:0] want  [2];
        prods = '{32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFA, 32'd20};
        want  = '{32'h0000_0001, 32'd14};
        cfg_len = 8'd2;
        for (int g = 0; g < 2; g++) begin
            beat(prods[2*g]);
            beat(prods[2*g+1]);
            istream_val = 0;
            @(negedge clk);
            total++;
            if (ostream_val !== 1'b1 || ostream_msg !== want[g] || ostream_cnt !== 8'd2) begin
                bad++;
                $display("FAIL wrap_%0d got val=%b msg=%h cnt=%0d want 1 %h 2",
                         g, ostream_val, ostream_msg, ostream_cnt, want[g]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_len_zero();
        cfg_len = 8'd0;
        beat(32'd7);
        istream_val = 0;
        @(negedge clk);
        total++;
        if (ostream_val !== 1'b1 || ostream_msg !== 32'd7 || ostream_cnt !== 8'd1) begin
            bad++; $display("FAIL len_zero got val=%b msg=%0d cnt=%0d want 1 7 1", ostream_val, ostream_msg, ostream_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        cfg_len = 8'd1;
        ostream_rdy = 1'b0;
        beat(32'd56);
        istream_val = 1'b1; istream_msg = 32'd99;   // offered but must not be taken
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (ostream_val !== 1'b1 || ostream_msg !== 32'd56 || ostream_cnt !== 8'd1 || istream_rdy !== 1'b0) begin
                bad++;
                $display("FAIL stall_%0d got val=%b msg=%0d cnt=%0d irdy=%b want 1 56 1 0",
                         i, ostream_val, ostream_msg, ostream_cnt, istream_rdy);
            end
        end
        istream_val = 0;
        ostream_rdy = 1'b1;
        @(posedge clk); #1;
        total++;
        if (ostream_val !== 1'b0 || istream_rdy !== 1'b1) begin
            bad++; $display("FAIL stall_release got oval=%b irdy=%b want 0 1", ostream_val, istream_rdy);
        end
    endtask

    task automatic test_mid_reset();
        cfg_len = 8'd4;
        beat(32'd10);
        beat(32'd13);
        istream_val = 0;
        total++;
        if (busy !== 1'b1 || ostream_val !== 1'b0) begin
            bad++; $display("FAIL midrst_pre got busy=%b oval=%b want 1 0", busy, ostream_val);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || istream_rdy !== 1'b1 || ostream_val !== 1'b0 ||
            ostream_msg !== 32'd0 || ostream_cnt !== '0) begin
            bad++;
            $display("FAIL midrst_async got busy=%b irdy=%b oval=%b msg=%h cnt=%0d want 0 1 0 0 0",
                     busy, istream_rdy, ostream_val, ostream_msg, ostream_cnt);
        end
        #1 reset = 1'b0;
        @(posedge clk); #1;
        cfg_len = 8'd1;
        beat(32'd5);
        istream_val = 0;
        @(negedge clk);
        total++;
        if (ostream_val !== 1'b1 || ostream_msg !== 32'd5 || ostream_cnt !== 8'd1) begin
            bad++; $display("FAIL midrst_residue got val=%b msg=%0d cnt=%0d want 1 5 1", ostream_val, ostream_msg, ostream_cnt);
        end
        @(posedge clk); #1;
    endtask

    // Random groups: random length (0 means 1), bubbles, cfg_len scribbled
    // after the first beat, and random output stalls.
    task automatic test_random();
        int n_err = 0;
        for (int g = 0; g < 500; g++) begin
            logic [31:0] q[$];
            logic [31:0] exp_sum;
            int          len_in, eff;
            len_in  = (g % 4 == 0) ? 3 : int'($urandom_range(0, 6));
            eff     = (len_in == 0) ? 1 : len_in;
            cfg_len = LW'(len_in);
            q.delete();
            for (int b = 0; b < eff; b++) begin
                istream_val = 0;
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                q.push_back($urandom);
                beat(q[b]);
                if (b == 0) cfg_len = (len_in == 3) ? 8'd9 : LW'($urandom_range(0, 12));
                if (b < eff - 1 && (ostream_val !== 1'b0 || istream_rdy !== 1'b1)) n_err++;
            end
            istream_val = 0;
            exp_sum = '0;
            foreach (q[k]) exp_sum = exp_sum + q[k];
            ostream_rdy = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            @(negedge clk);
            total++;
            if (ostream_val !== 1'b1 || ostream_msg !== exp_sum || ostream_cnt !== LW'(eff)) begin
                bad++;
                $display("FAIL rand_group_%0d got val=%b msg=%h cnt=%0d want 1 %h %0d",
                         g, ostream_val, ostream_msg, ostream_cnt, exp_sum, eff);
            end
            ostream_rdy = 1'b1;
            @(posedge clk); #1;
            if (ostream_val !== 1'b0 || istream_rdy !== 1'b1) n_err++;
        end
        total++;
        if (n_err != 0) begin
            bad++; $display("FAIL rand_handshake got %0d bad handshake cycles want 0", n_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_len_zero();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
